// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing stages.
// The SC_BIPOLAR_EN macro selects the bipolar result width.
package sc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } sc_state_t;

   // Result width of a window converter. Bipolar mode needs one extra bit for the sign.
   function automatic int sc_res_width(input int window_log2);
`ifdef SC_BIPOLAR_EN
      return window_log2 + 2;
`else
      return window_log2 + 1;
`endif
   endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Counts valid samples and ones over a 2**WINDOW_LOG2 window.
// It flags the final sample and exposes the ones count that includes the current bit.
module sc_ones_counter #(
   parameter int WINDOW_LOG2 = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 en,
   input  logic                 bit_in,
   output logic [WINDOW_LOG2:0] ones_next,
   output logic                 last
);

   logic [WINDOW_LOG2-1:0] sample_cnt;
   logic [WINDOW_LOG2:0]   ones_cnt;

   // ones_cnt has one spare bit, so an all-ones window cannot overflow.
   assign ones_next = ones_cnt + {{WINDOW_LOG2{1'b0}}, bit_in};
   assign last      = en && (sample_cnt == {WINDOW_LOG2{1'b1}});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sample_cnt <= '0;
         ones_cnt   <= '0;
      end else if (clear) begin
         sample_cnt <= '0;
         ones_cnt   <= '0;
      end else if (en) begin
         sample_cnt <= sample_cnt + {{(WINDOW_LOG2-1){1'b0}}, 1'b1};
         ones_cnt   <= ones_next;
      end
   end

endmodule

// File: rtl/sc_stream_to_binary.sv
// Converts a stochastic bitstream to a binary count over 2**WINDOW_LOG2 valid samples.
// If SC_BIPOLAR_EN is defined, the result is the two's-complement value 2*ones - 2**WINDOW_LOG2.
module sc_stream_to_binary
   import sc_pkg::*;
#(
   parameter int  WINDOW_LOG2 = 8,
   localparam int RES_W       = sc_res_width(WINDOW_LOG2)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             busy,
   output logic [RES_W-1:0] result,
   output logic             result_valid,
   input  logic             result_ready,
   output sc_state_t        state_dbg
);

   // Handshake: a result transfers on a rising edge where result_valid and result_ready
   // are both high. The output side holds result and result_valid until that edge.
   // The input side has no backpressure: samples seen outside ACCUM are dropped.

   sc_state_t            state, state_next;
   logic                 cnt_clear, cnt_en, load_result, drop_valid;
   logic                 last;
   logic [WINDOW_LOG2:0] ones_next;
   logic [RES_W-1:0]     result_d;

   sc_ones_counter #(.WINDOW_LOG2(WINDOW_LOG2)) u_counter (
      .clk       (clk),
      .rst       (rst),
      .clear     (cnt_clear),
      .en        (cnt_en),
      .bit_in    (bit_in),
      .ones_next (ones_next),
      .last      (last)
   );

`ifdef SC_BIPOLAR_EN
   assign result_d = {ones_next, 1'b0} - (RES_W'(1) << WINDOW_LOG2);
`else
   assign result_d = ones_next;
`endif

   assign busy      = (state == ST_ACCUM);
   assign state_dbg = state;

   always_comb begin
      state_next  = state;
      cnt_clear   = 1'b0;
      cnt_en      = 1'b0;
      load_result = 1'b0;
      drop_valid  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_ACCUM;
               cnt_clear  = 1'b1;
            end
         end
         ST_ACCUM: begin
            cnt_en = bit_valid;
            if (last) begin
               state_next  = ST_HOLD;
               load_result = 1'b1;
            end
         end
         ST_HOLD: begin
            // Restarting on the accept edge gives back-to-back windows.
            if (result_ready) begin
               drop_valid = 1'b1;
               cnt_clear  = start;
               state_next = start ? ST_ACCUM : ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         state <= state_next;
         if (load_result) begin
            result       <= result_d;
            result_valid <= 1'b1;
         end else if (drop_valid) begin
            result_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sc_stream_to_binary.sv
// Self-checking bench for sc_stream_to_binary with WINDOW_LOG2=4 (16-sample windows).
import sc_pkg::*;

module tb_sc_stream_to_binary;

   localparam int WL    = 4;
   localparam int WIN   = 1 << WL;
   localparam int RES_W = sc_res_width(WL);

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic             bit_in = 1'b0;
   logic             bit_valid = 1'b0;
   logic             busy;
   logic [RES_W-1:0] result;
   logic             result_valid;
   logic             result_ready = 1'b0;
   sc_state_t        state_dbg;

   logic [RES_W-1:0] exp_q[$];
   int               n_checks = 0;
   int               n_errors = 0;

   sc_stream_to_binary #(.WINDOW_LOG2(WL)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .bit_in       (bit_in),
      .bit_valid    (bit_valid),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .state_dbg    (state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [RES_W-1:0] model(input int ones);
      int v;
`ifdef SC_BIPOLAR_EN
      v = 2 * ones - WIN;
`else
      v = ones;
`endif
      return v[RES_W-1:0];
   endfunction

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start     = 1'b1;
      bit_valid = 1'($urandom_range(0, 1));
      bit_in    = 1'($urandom_range(0, 1));
      step();
      start     = 1'b0;
      bit_valid = 1'b0;
      check("start_busy", {31'd0, busy}, 32'd1);
   endtask

   // mode: 0 zeros, 1 ones, 2 alternating 1010.., 3 random
   // gaps: 0 none, 1 every 3rd cycle idle, 2 random idle cycles
   task automatic feed(input int mode, input int gaps, input bit start_noise);
      int n_valid = 0;
      int ones    = 0;
      int cyc     = 0;
      logic b;
      while (n_valid < WIN) begin
         start        = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
         result_ready = 1'($urandom_range(0, 1));
         if ((gaps == 1 && (cyc % 3) == 2) || (gaps == 2 && $urandom_range(0, 2) == 0)) begin
            bit_valid = 1'b0;
            bit_in    = 1'($urandom_range(0, 1));
         end else begin
            case (mode)
               0:       b = 1'b0;
               1:       b = 1'b1;
               2:       b = ((n_valid % 2) == 0);
               default: b = 1'($urandom_range(0, 1));
            endcase
            bit_valid = 1'b1;
            bit_in    = b;
            ones     += int'(b);
            n_valid++;
         end
         cyc++;
         step();
         if (n_valid < WIN) begin
            check("accum_valid_low", {31'd0, result_valid}, 32'd0);
            check("accum_busy", {31'd0, busy}, 32'd1);
         end
      end
      start        = 1'b0;
      bit_valid    = 1'b0;
      result_ready = 1'b0;
      exp_q.push_back(model(ones));
      // The result must be visible right after the final valid sample's edge.
      check("latency_valid", {31'd0, result_valid}, 32'd1);
      check("hold_state", {30'd0, state_dbg}, {30'd0, ST_HOLD});
   endtask

   task automatic collect(input bit restart);
      int budget = 50;
      logic [RES_W-1:0] exp;
      while (!result_valid && budget > 0) begin
         step();
         budget--;
      end
      check("result_valid_seen", {31'd0, result_valid}, 32'd1);
      if (exp_q.size() == 0) begin
         check("queue_nonempty", 32'd0, 32'd1);
      end else begin
         exp = exp_q.pop_front();
         check("result", {{(32-RES_W){1'b0}}, result}, {{(32-RES_W){1'b0}}, exp});
      end
      result_ready = 1'b1;
      start        = restart;
      step();
      result_ready = 1'b0;
      start        = 1'b0;
      check("accept_valid_low", {31'd0, result_valid}, 32'd0);
      check("accept_busy", {31'd0, busy}, {31'd0, restart});
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [RES_W-1:0] held;
      repeat (3) step();
      check("rst_result", {{(32-RES_W){1'b0}}, result}, 32'd0);
      check("rst_valid", {31'd0, result_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
      rst = 1'b1;
      step();

      // bit_valid in IDLE must not start anything
      bit_valid = 1'b1; bit_in = 1'b1;
      repeat (3) step();
      bit_valid = 1'b0;
      check("idle_stays", {30'd0, state_dbg}, {30'd0, ST_IDLE});

      // 1: all ones
      do_start(); feed(1, 0, 1'b0); collect(1'b0);
      check("idle_after_1", {30'd0, state_dbg}, {30'd0, ST_IDLE});
      // 2: all zeros
      do_start(); feed(0, 0, 1'b0); collect(1'b0);
      // 3: alternating with every third cycle idle
      do_start(); feed(2, 1, 1'b0); collect(1'b0);

      // 4: hold with backpressure, then back-to-back restart
      do_start(); feed(3, 2, 1'b0);
      held = result;
      for (int i = 0; i < 5; i++) begin
         start     = 1'(i % 2);
         bit_valid = 1'((i + 1) % 2);
         bit_in    = 1'b1;
         step();
         check("hold_result", {{(32-RES_W){1'b0}}, result}, {{(32-RES_W){1'b0}}, exp_q[0]});
         check("hold_stable", {{(32-RES_W){1'b0}}, result}, {{(32-RES_W){1'b0}}, held});
         check("hold_valid", {31'd0, result_valid}, 32'd1);
      end
      bit_valid = 1'b0;
      collect(1'b1);
      feed(1, 0, 1'b0); collect(1'b0);

      // 5: reset mid-window
      do_start();
      bit_valid = 1'b1; bit_in = 1'b1;
      repeat (7) step();
      bit_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("abort_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_valid", {31'd0, result_valid}, 32'd0);
      check("abort_result", {{(32-RES_W){1'b0}}, result}, 32'd0);
      step();
      rst = 1'b1;
      step();
      do_start(); feed(1, 0, 1'b0); collect(1'b0);

      // 6: start pulses during ACCUM are ignored
      do_start(); feed(2, 0, 1'b1); collect(1'b0);

      // random windows
      for (int w = 0; w < 4; w++) begin
         do_start(); feed(3, 2, 1'b1); collect(1'b0);
      end

      check("queue_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
